// File: rtl/tennis_pkg.sv
// rtl/tennis_pkg.sv - shared types and constants for the tennis match sequencer
package tennis_pkg;
  localparam int BALL_W  = 16;
  localparam int SCORE_W = 4;

  localparam logic SIDE_LEFT  = 1'b0;
  localparam logic SIDE_RIGHT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_RALLY     = 3'd2,
    ST_POINT     = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  // Scores stick at all-ones rather than wrapping back to zero.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/tennis_rally_ctrl_if.sv
// rtl/tennis_rally_ctrl_if.sv - press/ball inputs and trigger/score outputs of the sequencer
interface tennis_rally_ctrl_if;
  logic                            start;
  logic                            left_press;
  logic                            right_press;
  logic [tennis_pkg::BALL_W-1:0]   ball;
  logic                            left_trigger;
  logic                            right_trigger;
  logic                            ball_reset;
  logic [tennis_pkg::SCORE_W-1:0]  score_left;
  logic [tennis_pkg::SCORE_W-1:0]  score_right;
  logic                            server;
  logic                            game_over;
  logic                            winner;

  modport master (
    output start, left_press, right_press, ball,
    input  left_trigger, right_trigger, ball_reset,
    input  score_left, score_right, server, game_over, winner
  );

  modport slave (
    input  start, left_press, right_press, ball,
    output left_trigger, right_trigger, ball_reset,
    output score_left, score_right, server, game_over, winner
  );
endinterface

// File: rtl/hit_window_timer.sv
// rtl/hit_window_timer.sv - counts cycles the ball rests on an end LED, flags the last legal cycle
module hit_window_timer #(
  parameter int HIT_WINDOW = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);
  localparam int              CNT_W = 26;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HIT_WINDOW - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_cnt <= '0;
    else if (i_clear)  r_cnt <= '0;
    else if (i_enable) r_cnt <= r_cnt + 1'b1;
  end

  assign o_expire = i_enable && !i_clear && (r_cnt == LAST);
endmodule

// File: rtl/tennis_rally_ctrl.sv
// rtl/tennis_rally_ctrl.sv - qualifies serves/hits, detects misses, keeps score and picks a winner
module tennis_rally_ctrl
  import tennis_pkg::*;
#(
  parameter int HIT_WINDOW = 50_000_000,
  parameter int WIN_SCORE  = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  tennis_rally_ctrl_if.slave   bus
);
  state_t               r_state, w_next_state;
  logic                 r_left_trigger, w_left_trigger;
  logic                 r_right_trigger, w_right_trigger;
  logic                 r_ball_reset, w_ball_reset;
  logic [SCORE_W-1:0]   r_score_left, w_score_left;
  logic [SCORE_W-1:0]   r_score_right, w_score_right;
  logic [SCORE_W-1:0]   w_new_score;
  logic                 r_server, w_server;
  logic                 r_game_over, w_game_over;
  logic                 r_winner, w_winner;
  logic                 r_scorer, w_scorer;

  // Only an exact one-hot end position counts; glitchy ball codes are mid-court.
  logic w_left_end, w_right_end, w_at_end, w_in_rally;
  logic w_left_hit, w_right_hit, w_expire;

  assign w_left_end  = (bus.ball == {1'b1, {(BALL_W-1){1'b0}}});
  assign w_right_end = (bus.ball == BALL_W'(1));
  assign w_at_end    = w_left_end || w_right_end;
  assign w_in_rally  = (r_state == ST_RALLY);
  assign w_left_hit  = w_in_rally && w_left_end  && bus.left_press;
  assign w_right_hit = w_in_rally && w_right_end && bus.right_press;

  hit_window_timer #(.HIT_WINDOW(HIT_WINDOW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (!w_in_rally || w_left_hit || w_right_hit || !w_at_end),
    .i_enable (w_in_rally && w_at_end),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_left_trigger  <= 1'b0;
      r_right_trigger <= 1'b0;
      r_ball_reset    <= 1'b0;
      r_score_left    <= '0;
      r_score_right   <= '0;
      r_server        <= SIDE_LEFT;
      r_game_over     <= 1'b0;
      r_winner        <= SIDE_LEFT;
      r_scorer        <= SIDE_LEFT;
    end else begin
      r_state         <= w_next_state;
      r_left_trigger  <= w_left_trigger;
      r_right_trigger <= w_right_trigger;
      r_ball_reset    <= w_ball_reset;
      r_score_left    <= w_score_left;
      r_score_right   <= w_score_right;
      r_server        <= w_server;
      r_game_over     <= w_game_over;
      r_winner        <= w_winner;
      r_scorer        <= w_scorer;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_left_trigger  = 1'b0;
    w_right_trigger = 1'b0;
    w_ball_reset    = 1'b0;
    w_score_left    = r_score_left;
    w_score_right   = r_score_right;
    w_new_score     = '0;
    w_server        = r_server;
    w_winner        = r_winner;
    w_scorer        = r_scorer;
    case (r_state)
      ST_IDLE, ST_GAME_OVER: begin
        if (bus.start) begin
          w_score_left  = '0;
          w_score_right = '0;
          w_server      = SIDE_LEFT;
          w_ball_reset  = 1'b1;
          w_next_state  = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (r_server == SIDE_LEFT && bus.left_press) begin
          w_left_trigger = 1'b1;
          w_next_state   = ST_RALLY;
        end else if (r_server == SIDE_RIGHT && bus.right_press) begin
          w_right_trigger = 1'b1;
          w_next_state    = ST_RALLY;
        end
      end
      ST_RALLY: begin
        // A legal return on the last window cycle still beats the miss.
        if (w_left_hit) begin
          w_left_trigger = 1'b1;
        end else if (w_right_hit) begin
          w_right_trigger = 1'b1;
        end else if (w_expire) begin
          w_scorer     = w_left_end ? SIDE_RIGHT : SIDE_LEFT;
          w_next_state = ST_POINT;
        end
      end
      ST_POINT: begin
        w_new_score = sat_inc((r_scorer == SIDE_LEFT) ? r_score_left : r_score_right);
        if (r_scorer == SIDE_LEFT) w_score_left  = w_new_score;
        else                       w_score_right = w_new_score;
        if (w_new_score == SCORE_W'(WIN_SCORE)) begin
          w_winner     = r_scorer;
          w_next_state = ST_GAME_OVER;
        end else begin
          w_server     = ~r_server;
          w_ball_reset = 1'b1;
          w_next_state = ST_SERVE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
    w_game_over = (w_next_state == ST_GAME_OVER);
  end

  assign bus.left_trigger  = r_left_trigger;
  assign bus.right_trigger = r_right_trigger;
  assign bus.ball_reset    = r_ball_reset;
  assign bus.score_left    = r_score_left;
  assign bus.score_right   = r_score_right;
  assign bus.server        = r_server;
  assign bus.game_over     = r_game_over;
  assign bus.winner        = r_winner;
endmodule

// File: tb/tb_tennis_rally_ctrl.sv
// tb/tb_tennis_rally_ctrl.sv - directed scoreboard bench for tennis_rally_ctrl (HIT_WINDOW=8, WIN_SCORE=3)
module tb_tennis_rally_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  tennis_rally_ctrl_if bus ();

  tennis_rally_ctrl #(.HIT_WINDOW(8), .WIN_SCORE(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [13:0] val;
  } exp_t;

  exp_t sb[$];

  // Packs {left_trigger, right_trigger, ball_reset, score_left, score_right, server, game_over, winner}.
  function automatic logic [13:0] ev(input bit lt, input bit rt, input bit br, input int sl,
                                     input int sr, input bit srv, input bit go, input bit win);
    return {lt, rt, br, 4'(sl), 4'(sr), srv, go, win};
  endfunction

  task automatic compare_front();
    exp_t        e;
    logic [13:0] obs;
    e   = sb.pop_front();
    obs = {bus.left_trigger, bus.right_trigger, bus.ball_reset, bus.score_left,
           bus.score_right, bus.server, bus.game_over, bus.winner};
    checks++;
    assert (obs === e.val) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  task automatic step(input string tag, input bit st, input bit lp, input bit rp,
                      input logic [15:0] b, input logic [13:0] e);
    bus.start       = st;
    bus.left_press  = lp;
    bus.right_press = rp;
    bus.ball        = b;
    sb.push_back('{tag, e});
    @(posedge clk);
    #1;
    compare_front();
    bus.start       = 1'b0;
    bus.left_press  = 1'b0;
    bus.right_press = 1'b0;
  endtask

  task automatic hold(input string tag, input logic [15:0] b, input logic [13:0] e);
    for (int i = 0; i < 8; i++) step(tag, 1'b0, 1'b0, 1'b0, b, e);
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    bus.start       = 1'b0;
    bus.left_press  = 1'b0;
    bus.right_press = 1'b0;
    bus.ball        = '0;
    reset           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back('{"reset_state", ev(0,0,0,0,0,0,0,0)});
    compare_front();
    reset = 1'b0;

    step("start_ball_reset", 1,0,0,16'h0000, ev(0,0,1,0,0,0,0,0));
    step("ball_reset_1clk",  0,0,0,16'h0000, ev(0,0,0,0,0,0,0,0));
    step("serve_left",       0,1,0,16'h0000, ev(1,0,0,0,0,0,0,0));
    step("trigger_1clk",     0,0,0,16'h0000, ev(0,0,0,0,0,0,0,0));
    step("hit_left_end",     0,1,0,16'h8000, ev(1,0,0,0,0,0,0,0));
    step("press_mid_court",  0,1,0,16'h0100, ev(0,0,0,0,0,0,0,0));
    hold("miss1_window",     16'h0001,       ev(0,0,0,0,0,0,0,0));
    step("miss1_point",      0,0,0,16'h0000, ev(0,0,1,1,0,1,0,0));
    step("miss1_br_1clk",    0,0,0,16'h0000, ev(0,0,0,1,0,1,0,0));
    step("serve_wrong_side", 0,1,0,16'h0000, ev(0,0,0,1,0,1,0,0));
    step("serve_right",      0,0,1,16'h0000, ev(0,1,0,1,0,1,0,0));
    step("rtrig_1clk",       0,0,0,16'h0000, ev(0,0,0,1,0,1,0,0));
    hold("miss2_window",     16'h0001,       ev(0,0,0,1,0,1,0,0));
    step("miss2_point",      0,0,0,16'h0000, ev(0,0,1,2,0,0,0,0));
    step("miss2_br_1clk",    0,0,0,16'h0000, ev(0,0,0,2,0,0,0,0));
    step("serve_left2",      0,1,0,16'h0000, ev(1,0,0,2,0,0,0,0));
    step("ltrig_1clk",       0,0,0,16'h0000, ev(0,0,0,2,0,0,0,0));
    hold("miss3_window",     16'h0001,       ev(0,0,0,2,0,0,0,0));
    step("game_over_win",    0,0,0,16'h0000, ev(0,0,0,3,0,0,1,0));
    step("go_press_left",    0,1,1,16'h8000, ev(0,0,0,3,0,0,1,0));
    step("go_press_right",   0,0,1,16'h0001, ev(0,0,0,3,0,0,1,0));
    step("restart",          1,0,0,16'h0000, ev(0,0,1,0,0,0,0,0));
    step("serve_left3",      0,1,0,16'h0000, ev(1,0,0,0,0,0,0,0));
    step("both_press",       0,1,1,16'h8000, ev(1,0,0,0,0,0,0,0));
    hold("left_miss_window", 16'h8000,       ev(0,0,0,0,0,0,0,0));
    step("point_right",      0,0,0,16'h0000, ev(0,0,1,0,1,1,0,0));
    step("start_in_serve",   1,0,0,16'h0000, ev(0,0,0,0,1,1,0,0));
    step("serve_right2",     0,0,1,16'h0000, ev(0,1,0,0,1,1,0,0));
    step("rally_counting",   0,0,0,16'h8000, ev(0,0,0,0,1,1,0,0));

    reset = 1'b1;
    #1;
    sb.push_back('{"reset_mid_rally", ev(0,0,0,0,0,0,0,0)});
    compare_front();
    bus.left_press = 1'b1;
    bus.ball       = 16'h8000;
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("post_reset_press", 0,1,0,16'h8000, ev(0,0,0,0,0,0,0,0));
    step("post_reset_idle",  0,0,0,16'h0000, ev(0,0,0,0,0,0,0,0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
